// File: rtl/tone_pkg.sv
// Shared types and constants for the tone sequencer: FSM state encoding,
// the ROM end-of-song marker and the audio sample width.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SAMPLE_W = 32;

  // All-ones ROM word ends the song; the top slices it down to its ROM word width.
  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

endpackage

// File: rtl/square_osc.sv
// Square-wave oscillator: counts half-periods, toggles snd, and gates rests
// (half_period == 0) to a silent sample.
module square_osc
  import tone_pkg::*;
#(
  parameter int DELAY_W   = 19,
  parameter int AMPLITUDE = 100000000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       en,
  input  logic                       clr,
  input  logic [DELAY_W-1:0]         half_period,
  output logic signed [SAMPLE_W-1:0] sample
);

  localparam logic signed [SAMPLE_W-1:0] AMP = SAMPLE_W'(AMPLITUDE);

  logic [DELAY_W-1:0] half_cnt;
  logic               snd;
  logic               sounding;

  assign sounding = en && (half_period != '0);

  // clr restarts each note high; rests hold both counter and snd.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      half_cnt <= '0;
      snd      <= 1'b0;
    end else if (clr) begin
      half_cnt <= '0;
      snd      <= 1'b1;
    end else if (sounding) begin
      if (half_cnt == half_period) begin
        half_cnt <= '0;
        snd      <= ~snd;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    sample = '0;
    if (sounding) sample = snd ? AMP : -AMP;
  end

endmodule

// File: rtl/tone_sequencer.sv
// Melody player: steps through a note ROM one beat per word and streams a square
// wave into the Audio_Controller output FIFO, with start/stop and end-of-song handling.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DELAY_W    = 19,
  parameter int LAST_ADDR  = 999,
  parameter int BEAT_TICKS = 2500000,
  parameter int AMPLITUDE  = 100000000,
  parameter int ROM_LAT    = 1
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DELAY_W-1:0]  rom_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [SAMPLE_W-1:0] left_sample,
  output logic [SAMPLE_W-1:0] right_sample,
  output logic                playing,
  output logic                done
);

  localparam int BEAT_W = (BEAT_TICKS > 2) ? $clog2(BEAT_TICKS) : 1;
  localparam int FCNT_W = $clog2(ROM_LAT + 1);
  localparam logic [DELAY_W-1:0] END_CODE = END_MARKER[DELAY_W-1:0];

  state_t state, state_next;

  logic [BEAT_W-1:0]         beat_cnt;
  logic [FCNT_W-1:0]         fetch_cnt;
  logic [DELAY_W-1:0]        note_reg;
  logic [SAMPLE_W-1:0]       sample_reg;
  logic signed [SAMPLE_W-1:0] osc_sample;
  logic beat_expiry, fetch_ready, stop_abort;
  logic start_play, latch_note, advance_addr, wrap_addr;

  assign beat_expiry = (beat_cnt == BEAT_W'(BEAT_TICKS - 1));
  // rom_addr is registered, so rom_q is sampled ROM_LAT clocks after the first FETCH cycle.
  assign fetch_ready = (fetch_cnt == FCNT_W'(ROM_LAT));
  assign stop_abort  = stop && (state != IDLE);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    start_play   = 1'b0;
    latch_note   = 1'b0;
    advance_addr = 1'b0;
    wrap_addr    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_next = FETCH;
          start_play = 1'b1;
        end
      end
      FETCH: begin
        if (stop) begin
          state_next = DONE;
        end else if (fetch_ready) begin
          latch_note = 1'b1;
          state_next = (rom_q == END_CODE) ? DONE : PLAY;
        end
      end
      PLAY: begin
        if (stop) begin
          state_next = DONE;
        end else if (beat_expiry) begin
          if (rom_addr < ADDR_W'(LAST_ADDR)) begin
            advance_addr = 1'b1;
            state_next   = FETCH;
          end else if (loop_en) begin
            wrap_addr  = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat counter free-runs across FETCH so every ROM word lasts exactly BEAT_TICKS clocks.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rom_addr        <= '0;
      note_reg        <= '0;
      beat_cnt        <= '0;
      fetch_cnt       <= '0;
      write_audio_out <= 1'b0;
      sample_reg      <= '0;
    end else begin
      if (start_play || wrap_addr) rom_addr <= '0;
      else if (advance_addr)       rom_addr <= rom_addr + 1'b1;

      if (latch_note) note_reg <= rom_q;

      if ((state == FETCH || state == PLAY) && !beat_expiry) beat_cnt <= beat_cnt + 1'b1;
      else                                                   beat_cnt <= '0;

      if (state == FETCH && state_next == FETCH) fetch_cnt <= fetch_cnt + 1'b1;
      else                                       fetch_cnt <= '0;

      write_audio_out <= audio_out_allowed && !write_audio_out &&
                         (state_next == FETCH || state_next == PLAY);

      sample_reg <= stop_abort ? '0 : osc_sample;
    end
  end

  square_osc #(
    .DELAY_W   (DELAY_W),
    .AMPLITUDE (AMPLITUDE)
  ) u_osc (
    .clk         (CLOCK_50),
    .resetn      (resetn),
    .en          (state == PLAY),
    .clr         (state == FETCH),
    .half_period (note_reg),
    .sample      (osc_sample)
  );

  assign left_sample  = sample_reg;
  assign right_sample = sample_reg;
  assign playing      = (state == FETCH) || (state == PLAY);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: a behavioural ROM plus a per-cycle expected
// trace built from the melody rules (beat slots, half-period arithmetic, stop/end handling).
module tb_tone_sequencer;

  localparam int ADDR_W     = 10;
  localparam int DELAY_W    = 19;
  localparam int LAST_ADDR  = 3;
  localparam int BEAT_TICKS = 8;
  localparam int AMP        = 100;
  localparam int ROM_LAT    = 1;
  localparam int END_VAL    = (1 << DELAY_W) - 1;
  localparam int FETCH_CYCLES = ROM_LAT + 1;

  logic                CLOCK_50;
  logic                resetn, start, stop, loop_en, audio_out_allowed;
  logic [ADDR_W-1:0]   rom_addr;
  logic [DELAY_W-1:0]  rom_q;
  logic                write_audio_out, playing, done;
  logic [31:0]         left_sample, right_sample;

  int rom [4];

  typedef struct {
    bit active;
    bit is_done;
    bit stop_done;
    int addr;
    int osc;
  } cyc_t;

  cyc_t trace[$];
  bit   stop_applied;
  int   allow_mode;
  int   check_count = 0;
  int   error_count = 0;

  tone_sequencer #(
    .ADDR_W(ADDR_W), .DELAY_W(DELAY_W), .LAST_ADDR(LAST_ADDR),
    .BEAT_TICKS(BEAT_TICKS), .AMPLITUDE(AMP), .ROM_LAT(ROM_LAT)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_q(rom_q), .audio_out_allowed(audio_out_allowed),
    .write_audio_out(write_audio_out), .left_sample(left_sample), .right_sample(right_sample),
    .playing(playing), .done(done)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  always @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) rom_q <= '0;
    else         rom_q <= DELAY_W'(rom[rom_addr[1:0]]);
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed != expected) begin
      error_count++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int t, input bit is_active, input bit do_stop, input int spur_at);
    case (allow_mode)
      1:       audio_out_allowed = 1'($urandom_range(0, 1));
      2:       audio_out_allowed = (t >= 20 && t < 40) ? 1'b0 : 1'b1;
      default: audio_out_allowed = 1'b1;
    endcase
    stop  = do_stop;
    start = (t == spur_at) && is_active;
  endtask

  // Expected cycle-by-cycle picture of one playback, counted from the first FETCH cycle.
  task automatic buildTrace(input bit loop_mode, input int max_slots, input int stop_at);
    cyc_t e;
    bit   ended;
    int   a, h, tail_addr;
    trace.delete();
    ended = 0;
    a = 0;
    for (int k = 0; k < max_slots && !ended; k++) begin
      a = k % (LAST_ADDR + 1);
      h = rom[a];
      for (int p = 0; p < BEAT_TICKS && !ended; p++) begin
        e.addr = a; e.active = 1; e.is_done = 0; e.stop_done = 0; e.osc = 0;
        if (p == FETCH_CYCLES && h == END_VAL) begin
          e.active = 0; e.is_done = 1; ended = 1;
        end else if (p >= FETCH_CYCLES && h != 0) begin
          e.osc = ((((p - FETCH_CYCLES) / (h + 1)) % 2) == 0) ? AMP : -AMP;
        end
        trace.push_back(e);
      end
    end
    if (!ended && !loop_mode) begin
      e.addr = a; e.active = 0; e.is_done = 1; e.stop_done = 0; e.osc = 0;
      trace.push_back(e);
    end
    stop_applied = 0;
    if (stop_at >= 0 && stop_at < trace.size() && trace[stop_at].active) begin
      stop_applied = 1;
      while (trace.size() > stop_at + 1) void'(trace.pop_back());
      e.addr = trace[stop_at].addr; e.active = 0; e.is_done = 1; e.stop_done = 1; e.osc = 0;
      trace.push_back(e);
    end
    tail_addr = trace[trace.size() - 1].addr;
    for (int i = 0; i < 4; i++) begin
      e.addr = tail_addr; e.active = 0; e.is_done = 0; e.stop_done = 0; e.osc = 0;
      trace.push_back(e);
    end
  endtask

  task automatic runSong(input string name, input bit loop_mode, input int max_slots,
                         input int stop_at, input int mode, input int spur_at);
    cyc_t e;
    int exp_sample, exp_write, prev_osc, prev_write, prev_allowed;
    buildTrace(loop_mode, max_slots, stop_at);
    allow_mode = mode;
    $display("[TB] song %s: rom {%0d,%0d,%0d,%0d} loop=%0d, %0d cycles",
             name, rom[0], rom[1], rom[2], rom[3], loop_mode, trace.size());
    loop_en = loop_mode;
    audio_out_allowed = 1'b1;
    start = 1'b1;
    stop  = 1'b0;
    prev_osc = 0; prev_write = 0; prev_allowed = 1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    for (int t = 0; t < trace.size(); t++) begin
      e = trace[t];
      exp_sample = e.stop_done ? 0 : prev_osc;
      exp_write  = (e.active && prev_allowed != 0 && prev_write == 0) ? 1 : 0;
      checkOutput({name, ".playing"}, int'(playing), int'(e.active));
      checkOutput({name, ".done"}, int'(done), int'(e.is_done));
      checkOutput({name, ".rom_addr"}, int'(rom_addr), e.addr);
      checkOutput({name, ".left"}, $signed(left_sample), exp_sample);
      checkOutput({name, ".right"}, $signed(right_sample), exp_sample);
      checkOutput({name, ".write"}, int'(write_audio_out), exp_write);
      applyStimulus(t, e.active, stop_applied && (t == stop_at), spur_at);
      prev_osc = e.osc;
      prev_write = exp_write;
      prev_allowed = int'(audio_out_allowed);
      @(posedge CLOCK_50); #1;
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int v, lm;
    resetn = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; audio_out_allowed = 1'b0;
    allow_mode = 0;
    for (int i = 0; i < 4; i++) rom[i] = 0;
    #12;
    checkOutput("reset.playing", int'(playing), 0);
    checkOutput("reset.done", int'(done), 0);
    checkOutput("reset.rom_addr", int'(rom_addr), 0);
    checkOutput("reset.write", int'(write_audio_out), 0);
    checkOutput("reset.left", $signed(left_sample), 0);
    checkOutput("reset.right", $signed(right_sample), 0);
    #11 resetn = 1'b1;
    @(posedge CLOCK_50); #1;

    rom = '{2, 2, 2, 2};
    runSong("basic", 1'b0, 4, -1, 0, 12);
    rom = '{0, 5, 0, 5};
    runSong("rests", 1'b0, 4, -1, 1, -1);
    rom = '{3, 3, 3, 3};
    runSong("loop", 1'b1, 14, 13 * BEAT_TICKS + 4, 0, 40);
    rom = '{4, END_VAL, 4, 4};
    runSong("endmark", 1'b0, 4, -1, 0, -1);
    rom = '{6, 6, 6, 6};
    runSong("backpressure", 1'b0, 4, -1, 2, -1);
    rom = '{3, 3, 3, 3};
    runSong("stop_play", 1'b0, 4, 2 * BEAT_TICKS + 4, 1, -1);
    rom = '{2, 5, 1, 4};
    runSong("stop_expiry", 1'b0, 4, BEAT_TICKS + 7, 0, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        v = int'($urandom_range(0, 7));
        rom[i] = (v == 7) ? END_VAL : v;
      end
      lm = int'($urandom_range(0, 1));
      if (lm == 1)
        runSong("random_loop", 1'b1, 6, int'($urandom_range(0, 6 * BEAT_TICKS - 1)), 1,
                int'($urandom_range(0, 30)));
      else
        runSong("random_once", 1'b0, 4,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : -1, 1,
                int'($urandom_range(0, 30)));
    end

    // start and stop together while idle: stop wins
    start = 1'b1; stop = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("startstop.playing", int'(playing), 0);
      checkOutput("startstop.done", int'(done), 0);
      checkOutput("startstop.write", int'(write_audio_out), 0);
      @(posedge CLOCK_50); #1;
    end

    // asynchronous reset in the middle of a sounding note
    rom = '{2, 3, 2, 3};
    loop_en = 1'b0; audio_out_allowed = 1'b1; start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    repeat (12) begin
      @(posedge CLOCK_50); #1;
    end
    checkOutput("prereset.playing", int'(playing), 1);
    checkOutput("prereset.rom_addr", int'(rom_addr), 1);
    checkOutput("prereset.left", $signed(left_sample), AMP);
    #3 resetn = 1'b0;
    #1;
    checkOutput("async_reset.playing", int'(playing), 0);
    checkOutput("async_reset.done", int'(done), 0);
    checkOutput("async_reset.rom_addr", int'(rom_addr), 0);
    checkOutput("async_reset.write", int'(write_audio_out), 0);
    checkOutput("async_reset.left", $signed(left_sample), 0);
    checkOutput("async_reset.right", $signed(right_sample), 0);
    @(posedge CLOCK_50); #1;
    checkOutput("reset_hold.done", int'(done), 0);
    #4 resetn = 1'b1;
    @(posedge CLOCK_50); #1;
    checkOutput("post_reset.done", int'(done), 0);
    checkOutput("post_reset.playing", int'(playing), 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
